// File: rtl/lc3b_types.sv
// Shared LC3X execute-stage types: data word, ALU opcodes and the
// multiply/divide sequencer states.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        alu_add,
        alu_and,
        alu_not,
        alu_pass,
        alu_sll,
        alu_srl,
        alu_sra,
        alu_mult,
        alu_div
    } lc3b_aluop;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } lc3b_muldiv_state;

    localparam int MULDIV_ITER = 16;

endpackage

// File: rtl/muldiv_control.sv
// Sequencer for the iterative multiply/divide unit: three-state FSM plus
// the iteration counter, emitting strobes for the datapath.
module muldiv_control
    import lc3b_types::*;
#(
    parameter int ITER = MULDIV_ITER
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic valid_op,
    input  logic zero_div,
    output logic load,
    output logic step,
    output logic finish,
    output logic busy,
    output logic done
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    lc3b_muldiv_state state, state_nxt;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value regardless of block order.
            state <= state_nxt;
            if (load)
                cnt <= '0;
            else if (step)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start && valid_op) begin
                    load      = 1'b1;
                    state_nxt = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pure decodes of the state register, so these cannot glitch on inputs.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit for the
// LC3X execute stage; one bit per cycle, results held until the next start.
module muldiv_unit
    import lc3b_types::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  lc3b_aluop        aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic valid_op, zero_div, load, step, finish;

    assign valid_op = (aluop == alu_mult) || (aluop == alu_div);
    assign zero_div = (aluop == alu_div) && (b == '0);

    muldiv_control #(.ITER(ITER)) u_control (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .valid_op (valid_op),
        .zero_div (zero_div),
        .load     (load),
        .step     (step),
        .finish   (finish),
        .busy     (busy),
        .done     (done)
    );

    // opa: multiplicand (mul) or dividend/quotient shifter (div).
    // opb: multiplier shifter (mul) or divisor (div).
    // acc: product accumulator (mul) or partial remainder (div).
    logic             op_div;
    logic [WIDTH-1:0] opa, opb, opa_nxt, opb_nxt;
    logic [WIDTH:0]   acc, acc_nxt, shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] mul_sum;
    logic             borrow;

    always_comb begin
        mul_sum = acc[WIDTH-1:0] + opa;
        shifted = {acc[WIDTH-1:0], opa[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, opb};
        borrow  = trial[WIDTH+1];
        acc_nxt = acc;
        opa_nxt = opa;
        opb_nxt = opb;
        if (op_div) begin
            // Restore (keep the shifted value) when the trial subtract borrows.
            acc_nxt = borrow ? shifted : trial[WIDTH:0];
            opa_nxt = {opa[WIDTH-2:0], ~borrow};
        end else begin
            acc_nxt = opb[0] ? {1'b0, mul_sum} : acc;
            opa_nxt = opa << 1;
            opb_nxt = opb >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the working registers are reset too; they are few and a
            // known state after an aborted op keeps simulation X-free.
            op_div      <= 1'b0;
            opa         <= '0;
            opb         <= '0;
            acc         <= '0;
            result      <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (load) begin
            op_div      <= (aluop == alu_div);
            opa         <= a;
            opb         <= b;
            acc         <= '0;
            div_by_zero <= zero_div;
            if (zero_div) begin
                result    <= '1;
                remainder <= a;
            end
        end else if (step) begin
            opa <= opa_nxt;
            opb <= opb_nxt;
            acc <= acc_nxt;
            if (finish) begin
                result    <= op_div ? opa_nxt : acc_nxt[WIDTH-1:0];
                remainder <= op_div ? acc_nxt[WIDTH-1:0] : '0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, divide by
// zero, ignored starts, invalid ops and mid-operation reset.
module tb_muldiv_unit;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    lc3b_aluop   aluop = alu_add;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] result, remainder;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(16), .ITER(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .aluop       (aluop),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle, scramble operands, then wait (bounded) for done.
    task automatic run_op(input lc3b_aluop op, input logic [15:0] x, input logic [15:0] y,
                          output int lat);
        @(negedge clk);
        start = 1'b1; aluop = op; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
        lat = 1;
        check("busy_after_start", 32'(busy), 32'd1);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_pulse_end(input string tag);
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int ndone;

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_rem", 32'(remainder), 32'h0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        reset_n = 1'b1;

        run_op(alu_mult, 16'd7, 16'd9, lat);
        check("mul7x9_lat", 32'(lat), 32'd17);
        check("mul7x9_res", 32'(result), 32'h003F);
        check("mul7x9_rem", 32'(remainder), 32'h0);
        check_pulse_end("mul7x9");

        run_op(alu_mult, 16'hFFFF, 16'hFFFF, lat);
        check("mulffff_lat", 32'(lat), 32'd17);
        check("mulffff_res", 32'(result), 32'h0001);

        run_op(alu_mult, 16'h1234, 16'h0010, lat);
        check("mulshift_res", 32'(result), 32'h2340);

        run_op(alu_div, 16'd100, 16'd7, lat);
        check("div100_7_lat", 32'(lat), 32'd17);
        check("div100_7_res", 32'(result), 32'd14);
        check("div100_7_rem", 32'(remainder), 32'd2);
        check("div100_7_dbz", 32'(div_by_zero), 32'd0);
        check_pulse_end("div100_7");

        run_op(alu_div, 16'hFFFF, 16'h8001, lat);
        check("divbig_res", 32'(result), 32'd1);
        check("divbig_rem", 32'(remainder), 32'h7FFE);

        run_op(alu_div, 16'd5, 16'd0, lat);
        check("dbz_lat", 32'(lat), 32'd1);
        check("dbz_res", 32'(result), 32'hFFFF);
        check("dbz_rem", 32'(remainder), 32'd5);
        check("dbz_flag", 32'(div_by_zero), 32'd1);
        check_pulse_end("dbz");
        check("dbz_hold", 32'(div_by_zero), 32'd1);

        // Invalid op: start is ignored and the unit stays idle.
        @(negedge clk);
        start = 1'b1; aluop = alu_add; a = 16'd1; b = 16'd1;
        @(negedge clk);
        start = 1'b0;
        check("badop_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("badop_done", 32'(done), 32'd0);
        check("badop_hold", 32'(result), 32'hFFFF);

        // 10x10 with a second start pulsed during CALC.
        @(negedge clk);
        start = 1'b1; aluop = alu_mult; a = 16'd10; b = 16'd10;
        @(negedge clk);
        start = 1'b0;
        check("mul10_dbz_clr", 32'(div_by_zero), 32'd0);
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 2) begin
                start = 1'b1; a = 16'd3; b = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (done) ndone++;
            @(negedge clk);
        end
        start = 1'b0;
        check("mul10_ndone", 32'(ndone), 32'd1);
        check("mul10_res", 32'(result), 32'd100);
        check("mul10_rem", 32'(remainder), 32'd0);

        // Reset mid-divide: asynchronous abort, no done afterwards.
        @(negedge clk);
        start = 1'b1; aluop = alu_div; a = 16'd1000; b = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_busy_pre", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'h0);
        check("abort_rem", 32'(remainder), 32'h0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        run_op(alu_mult, 16'd2, 16'd3, lat);
        check("mul2x3_lat", 32'(lat), 32'd17);
        check("mul2x3_res", 32'(result), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
